// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the fetch-stage program counter, drives the instruction
// memory address, and hands {pc, instr} pairs to decode through a 2-entry
// valid/ready buffer. Branch redirects flush the buffer and realign the PC.
module fetch_pc_unit #(
    parameter int              WORD     = 64,
    parameter logic [WORD-1:0] RESET_PC = '0,
    parameter int              INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [WORD-1:0]    branch_target,
    output logic [WORD-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [WORD-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               id_ready,
    output logic               align_fault
);

    logic [WORD-1:0]    pc;
    logic [1:0]         count;
    logic [WORD-1:0]    tail_pc;
    logic [INSTR_W-1:0] tail_instr;
    logic               pop;
    logic               fetch;

    // The head entry is kept directly in the output registers so if_pc and
    // if_instr are registered and hold steady while decode backpressures.
    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign pop       = if_valid & id_ready;
    // reset is asynchronous, so inside the clocked logic it is already low
    // whenever fetch matters; it is kept here to mirror the handshake rule.
    assign fetch     = !reset & !stall & !branch_taken & ((count != 2'd2) | pop);

    // PC register, 2-entry FIFO buffer and registered alignment fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: buffer storage is reset too, because the head entry doubles
            // as the if_pc/if_instr outputs, which must read zero after reset.
            pc          <= RESET_PC;
            count       <= 2'd0;
            if_pc       <= '0;
            if_instr    <= '0;
            tail_pc     <= '0;
            tail_instr  <= '0;
            align_fault <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of pc/count regardless of statement order.
            align_fault <= 1'b0;
            if (branch_taken) begin
                // Redirect wins over stall and fetch; any in-flight pop and
                // the fetch at the old PC are discarded with the flush.
                pc          <= {branch_target[WORD-1:2], 2'b00};
                count       <= 2'd0;
                align_fault <= |branch_target[1:0];
            end else begin
                if (fetch) begin
                    pc <= pc + WORD'(4);
                end
                unique case ({fetch, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            if_pc    <= pc;
                            if_instr <= imem_instr;
                        end else begin
                            tail_pc    <= pc;
                            tail_instr <= imem_instr;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        if_pc    <= tail_pc;
                        if_instr <= tail_instr;
                        count    <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            if_pc    <= pc;
                            if_instr <= imem_instr;
                        end else begin
                            if_pc      <= tail_pc;
                            if_instr   <= tail_instr;
                            tail_pc    <= pc;
                            tail_instr <= imem_instr;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors for fetch_pc_unit, with a second instance
// using a PC reset value just below the 64-bit wrap point.
module tb_fetch_pc_unit;

    localparam int              WORD    = 64;
    localparam int              INSTR_W = 32;
    localparam logic [WORD-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0]     SALT    = 32'h1357_9BDF;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic               branch_taken;
    logic [WORD-1:0]    branch_target;
    logic               id_ready;

    logic [WORD-1:0]    imem_addr,  imem_addr2;
    logic [INSTR_W-1:0] imem_instr, imem_instr2;
    logic               if_valid,   if_valid2;
    logic [WORD-1:0]    if_pc,      if_pc2;
    logic [INSTR_W-1:0] if_instr,   if_instr2;
    logic               align_fault, align_fault2;

    int total = 0;
    int bad   = 0;

    // Clock generation, 10 time-unit period.
    always #5 clk = ~clk;

    // Instruction memory model: the word is a fixed scramble of its address.
    function automatic logic [INSTR_W-1:0] instr_of(input logic [WORD-1:0] a);
        return a[31:0] ^ SALT;
    endfunction

    assign imem_instr  = instr_of(imem_addr);
    assign imem_instr2 = instr_of(imem_addr2);

    fetch_pc_unit #(.WORD(WORD), .RESET_PC('0), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .id_ready(id_ready), .align_fault(align_fault)
    );

    fetch_pc_unit #(.WORD(WORD), .RESET_PC(WRAP_PC), .INSTR_W(INSTR_W)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2),
        .id_ready(id_ready), .align_fault(align_fault2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [WORD-1:0] exp_pc);
        check({tag, ".valid"}, 64'(if_valid), 64'd1);
        check({tag, ".pc"},    if_pc,         exp_pc);
        check({tag, ".instr"}, 64'(if_instr), 64'(instr_of(exp_pc)));
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        id_ready      = 1'b1;

        // Reset state, held across a couple of edges.
        step();
        step();
        check("rst.imem_addr", imem_addr,          64'h0);
        check("rst.valid",     64'(if_valid),      64'd0);
        check("rst.if_pc",     if_pc,              64'h0);
        check("rst.if_instr",  64'(if_instr),      64'h0);
        check("rst.fault",     64'(align_fault),   64'd0);
        check("rst.wrap_addr", imem_addr2,         WRAP_PC);

        // Release: first fetch on the first edge with reset low.
        reset = 1'b0;
        step();
        expect_head("run0", 64'h0);
        check("run0.addr",     imem_addr, 64'h4);
        check("wrap0.valid",   64'(if_valid2), 64'd1);
        check("wrap0.pc",      if_pc2,         WRAP_PC);
        check("wrap0.addr",    imem_addr2,     64'h0);
        step();
        expect_head("run1", 64'h4);
        check("run1.addr",     imem_addr, 64'h8);
        check("wrap1.pc",      if_pc2,    64'h0);
        step();
        expect_head("run2", 64'h8);
        step();
        expect_head("run3", 64'hC);

        // Backpressure: buffer fills with 12 and 16, pc freezes at 20.
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_head("hold", 64'hC);
            check("hold.addr", imem_addr, 64'd20);
        end
        id_ready = 1'b1;
        step();
        expect_head("resume0", 64'd16);
        step();
        expect_head("resume1", 64'd20);
        step();
        expect_head("resume2", 64'd24);

        // Fill the buffer again (24, 28), then redirect to 0x100.
        id_ready = 1'b0;
        step();
        expect_head("full", 64'd24);
        check("full.addr", imem_addr, 64'd32);
        branch_taken  = 1'b1;
        branch_target = 64'h100;
        step();
        branch_taken = 1'b0;
        id_ready     = 1'b1;
        check("br.valid", 64'(if_valid), 64'd0);
        check("br.addr",  imem_addr,     64'h100);
        check("br.fault", 64'(align_fault), 64'd0);
        step();
        expect_head("br0", 64'h100);
        step();
        expect_head("br1", 64'h104);

        // Redirect together with stall; stall held for three cycles.
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 64'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            branch_taken = 1'b0;
            check("stbr.valid", 64'(if_valid), 64'd0);
            check("stbr.addr",  imem_addr,     64'h200);
        end
        stall = 1'b0;
        step();
        expect_head("stbr0", 64'h200);

        // Misaligned redirect: single-cycle fault, fetch resumes at 0x100.
        branch_taken  = 1'b1;
        branch_target = 64'h103;
        step();
        branch_taken = 1'b0;
        check("mis.fault", 64'(align_fault), 64'd1);
        check("mis.addr",  imem_addr,        64'h100);
        check("mis.valid", 64'(if_valid),    64'd0);
        step();
        check("mis.fault_off", 64'(align_fault), 64'd0);
        expect_head("mis0", 64'h100);
        step();
        expect_head("mis1", 64'h104);

        // Asynchronous reset mid-burst, observed before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("arst.valid",     64'(if_valid),  64'd0);
        check("arst.addr",      imem_addr,      64'h0);
        check("arst.wrap_addr", imem_addr2,     WRAP_PC);
        check("arst.if_pc",     if_pc,          64'h0);
        step();
        reset = 1'b0;
        step();
        expect_head("rerun0", 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Sequential owner of the program counter in the fetch stage.
- Holds PC, drives the instruction-memory address, computes PC+4 (modulo 2^WORD), and applies branch redirects.
- Hands {pc, instr} pairs to decode through a 2-entry valid/ready buffer, so decode backpressure never drops or duplicates an instruction.

Parameters:
- WORD, 64, datapath width of PC, branch target and instruction bus (matches `WORD).
- RESET_PC, 0, PC value loaded on reset.
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall from control; blocks new fetches.
- branch_taken  input  1  redirect request (PCSrc), single-cycle pulse.
- branch_target  input  WORD  redirect address.
- imem_addr  output  WORD  instruction-memory address; equals current PC, combinational.
- imem_instr  input  INSTR_W  instruction read combinationally from imem_addr in the same cycle.
- if_valid  output  1  buffer head holds a valid instruction.
- if_pc  output  WORD  PC of the head instruction.
- if_instr  output  INSTR_W  head instruction.
- id_ready  input  1  decode accepts the head this cycle.
- align_fault  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Behaviour:
Reset:
- Asynchronous reset applies immediately, mid-operation included.
- pc = RESET_PC, buffer count = 0, if_valid = 0, if_pc = 0, if_instr = 0, align_fault = 0.
- No fetch occurs in the reset cycle. The first fetch happens on the first rising edge with reset low.

Per-cycle signals:
- pop = if_valid & id_ready.
- fetch = !reset & !stall & !branch_taken & (count < 2 | pop).

Fetch:
- On fetch, {pc, imem_instr} is pushed at the buffer tail, and pc <= pc + 4.
- The sum is truncated to WORD bits, so RESET_PC = 2^WORD-4 wraps to 0.

Latency:
- An instruction fetched in cycle N is visible at if_valid/if_pc/if_instr in cycle N+1.
- With id_ready held at 1, throughput is 1 instruction per cycle.

Buffer:
- 2 entries, FIFO order. count goes 0..2.
- Push and pop in the same cycle leave count unchanged and move the second entry to the head.
- Push while full is allowed only when pop is also asserted.
- if_valid = (count != 0). Head outputs are registered and stable while if_valid & !id_ready.

Stall:
- pc holds and no push occurs.
- Pops continue, so the buffer drains to decode.

Branch redirect (priority: reset > branch_taken > stall > fetch):
- pc <= {branch_target[WORD-1:2], 2'b00}.
- Buffer is flushed (count <= 0), including any entry that would pop this cycle. Decode must ignore the handshake in a redirect cycle.
- The fetch at the old PC in that cycle is discarded.
- The first target instruction appears at if_valid two cycles after the branch_taken cycle.
- align_fault <= |branch_target[1:0] for one cycle, registered.
- branch_taken with stall=1 still redirects; the stall only blocks the following fetches.

Invariants:
- if_pc values delivered between redirects increase by exactly 4.
- No instruction is delivered twice and none is lost.

Test Plan:
- Reset with id_ready=1, then release: imem_addr=0 during reset, cycle 1 if_valid=1 with if_pc=0, then if_pc=4, 8, 12 on consecutive cycles; imem_addr runs 1 ahead of if_pc.
- Free run, then id_ready=0 for 5 cycles: buffer holds exactly 2 entries (if_pc=X, X+4), pc freezes at X+8. On id_ready=1, if_pc sequence X, X+4, X+8, X+12 resumes with no gap or repeat.
- Buffer full, branch_taken with branch_target=0x100: next cycle if_valid=0, imem_addr=0x100. Following cycle if_valid=1 with if_pc=0x100, then 0x104.
- stall=1 and branch_taken=1 with target 0x200 in the same cycle, stall held 3 cycles: pc=0x200 stays frozen, if_valid=0 during the stall; if_pc=0x200 appears 1 cycle after stall drops.
- branch_target=0x103: align_fault pulses for exactly 1 cycle and the fetch resumes at 0x100.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC: if_pc=...FFFC then 0. Assert reset asynchronously mid-burst: if_valid=0 and pc=RESET_PC immediately, without waiting for a clock edge.
